// File: rtl/hvsync_generator.sv
// Free-running raster timing: pixel/line counters, registered sync pulses and a visible-area flag.
// Syncs are decoded from the counters' next values, so they line up with hpos/vpos with no lag.
module hvsync_generator #(
  parameter int H_DISPLAY        = 256,
  parameter int H_FRONT          = 7,
  parameter int H_SYNC           = 23,
  parameter int H_BACK           = 23,
  parameter int V_DISPLAY        = 240,
  parameter int V_BOTTOM         = 14,
  parameter int V_SYNC           = 3,
  parameter int V_TOP            = 5,
  parameter int SYNC_ACTIVE_HIGH = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [8:0] hpos,
  output logic [8:0] vpos
);

  localparam logic [8:0] H_MAX        = 9'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [8:0] H_SYNC_START = 9'(H_DISPLAY + H_FRONT);
  localparam logic [8:0] H_SYNC_END   = 9'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [8:0] H_VISIBLE    = 9'(H_DISPLAY);
  localparam logic [8:0] V_MAX        = 9'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
  localparam logic [8:0] V_SYNC_START = 9'(V_DISPLAY + V_BOTTOM);
  localparam logic [8:0] V_SYNC_END   = 9'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
  localparam logic [8:0] V_VISIBLE    = 9'(V_DISPLAY);
  localparam logic       SYNC_ON      = (SYNC_ACTIVE_HIGH != 0);

  logic [8:0] hpos_q, hpos_d;
  logic [8:0] vpos_q, vpos_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;

  always_comb begin
    hpos_d  = hpos_q + 9'd1;
    vpos_d  = vpos_q;
    if (hpos_q == H_MAX) begin
      hpos_d = 9'd0;
      vpos_d = (vpos_q == V_MAX) ? 9'd0 : vpos_q + 9'd1;
    end
    // Decode from the values the counters are about to take, so sync and position change together.
    hsync_d = ((hpos_d >= H_SYNC_START) && (hpos_d <= H_SYNC_END)) ? SYNC_ON : ~SYNC_ON;
    vsync_d = ((vpos_d >= V_SYNC_START) && (vpos_d <= V_SYNC_END)) ? SYNC_ON : ~SYNC_ON;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hpos_q  <= 9'd0;
      vpos_q  <= 9'd0;
      hsync_q <= ~SYNC_ON;
      vsync_q <= ~SYNC_ON;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign hpos       = hpos_q;
  assign vpos       = vpos_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign display_on = (hpos_q < H_VISIBLE) && (vpos_q < V_VISIBLE);

endmodule

// File: tb/tb_hvsync_generator.sv
// Directed bench for hvsync_generator: reset, mid-line async reset, then one full frame walk
// with point checks at the sync/visible boundaries and per-cycle sequence tallies.
module tb_hvsync_generator;

  logic       clk;
  logic       reset;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic [8:0] hpos;
  logic [8:0] vpos;

  int n_checks;
  int n_pass;

  hvsync_generator dut (
    .clk        (clk),
    .reset      (reset),
    .hsync      (hsync),
    .vsync      (vsync),
    .display_on (display_on),
    .hpos       (hpos),
    .vpos       (vpos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int mh, mv;
    int max_h, max_v;
    int h_seq_err, v_seq_err, hs_err, vs_err;
    int hs_high_line5;
    int first_zero;
    int prev_h, prev_v;

    n_checks = 0;
    n_pass   = 0;

    // Reset asserted: state must be cleared with no reliance on edges.
    reset = 1'b0;
    #3;
    check("rst_hpos", int'(hpos), 0);
    check("rst_vpos", int'(vpos), 0);
    check("rst_hsync", int'(hsync), 0);
    check("rst_vsync", int'(vsync), 0);
    check("rst_display_on", int'(display_on), 1);

    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("start_hpos%0d", i), int'(hpos), i);
      check($sformatf("start_vpos%0d", i), int'(vpos), 0);
      check($sformatf("start_hsync%0d", i), int'(hsync), 0);
    end
    check("start_display_on", int'(display_on), 1);

    // Advance to (270,1), inside the hsync pulse, then reset between edges.
    for (int i = 6; i <= 309 + 270; i++) step();
    check("pre_rst_hpos", int'(hpos), 270);
    check("pre_rst_vpos", int'(vpos), 1);
    check("pre_rst_hsync", int'(hsync), 1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_hpos", int'(hpos), 0);
    check("async_rst_vpos", int'(vpos), 0);
    check("async_rst_hsync", int'(hsync), 0);
    check("async_rst_vsync", int'(vsync), 0);
    for (int i = 0; i < 3; i++) step();
    check("rst_hold_hpos", int'(hpos), 0);
    check("rst_hold_vpos", int'(vpos), 0);
    check("rst_hold_hsync", int'(hsync), 0);

    @(negedge clk);
    reset = 1'b1;

    mh = 0; mv = 0;
    max_h = 0; max_v = 0;
    h_seq_err = 0; v_seq_err = 0; hs_err = 0; vs_err = 0;
    hs_high_line5 = 0;
    first_zero = -1;
    prev_h = 0; prev_v = 0;

    for (int cyc = 1; cyc <= 80958; cyc++) begin
      step();
      if (mh == 308) begin
        mh = 0;
        mv = (mv == 261) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end

      if (int'(hpos) != mh) h_seq_err++;
      if (int'(vpos) != mv) v_seq_err++;
      if (int'(hsync) != int'(mh >= 263 && mh <= 285)) hs_err++;
      if (int'(vsync) != int'(mv >= 254 && mv <= 256)) vs_err++;
      if (int'(hpos) > max_h) max_h = int'(hpos);
      if (int'(vpos) > max_v) max_v = int'(vpos);
      if (vpos == 9'd5 && hsync) hs_high_line5++;
      if (first_zero < 0 && hpos == 9'd0 && vpos == 9'd0) first_zero = cyc;

      if (vpos == 9'd0) begin
        if (hpos == 9'd262) check("hsync_at_262", int'(hsync), 0);
        if (hpos == 9'd263) check("hsync_at_263", int'(hsync), 1);
        if (hpos == 9'd285) check("hsync_at_285", int'(hsync), 1);
        if (hpos == 9'd286) check("hsync_at_286", int'(hsync), 0);
        if (hpos == 9'd256) check("disp_256_0", int'(display_on), 0);
      end
      if (prev_h == 308 && prev_v == 0) begin
        check("line_wrap_hpos", int'(hpos), 0);
        check("line_wrap_vpos", int'(vpos), 1);
      end
      if (hpos == 9'd255 && vpos == 9'd239) check("disp_255_239", int'(display_on), 1);
      if (hpos == 9'd0 && vpos == 9'd240) check("disp_0_240", int'(display_on), 0);
      if (hpos == 9'd308 && vpos == 9'd261) check("disp_308_261", int'(display_on), 0);
      if (hpos == 9'd0 && vpos == 9'd253) check("vsync_line253", int'(vsync), 0);
      if (hpos == 9'd0 && vpos == 9'd254) check("vsync_line254", int'(vsync), 1);
      if (hpos == 9'd308 && vpos == 9'd256) check("vsync_line256_end", int'(vsync), 1);
      if (hpos == 9'd0 && vpos == 9'd257) check("vsync_line257", int'(vsync), 0);
      if (cyc == 80957) begin
        check("frame_end_hpos", int'(hpos), 308);
        check("frame_end_vpos", int'(vpos), 261);
      end
      prev_h = int'(hpos);
      prev_v = int'(vpos);
    end

    check("frame_wrap_hpos", int'(hpos), 0);
    check("frame_wrap_vpos", int'(vpos), 0);
    check("frame_period", first_zero, 80958);
    check("hpos_max", max_h, 308);
    check("vpos_max", max_v, 261);
    check("hsync_width_line5", hs_high_line5, 23);
    check("hpos_seq_errors", h_seq_err, 0);
    check("vpos_seq_errors", v_seq_err, 0);
    check("hsync_errors", hs_err, 0);
    check("vsync_errors", vs_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
